// File: rtl/prbs_checker.sv
// Self-synchronising LFSR bit-stream checker with lock, error and loss tracking.
// Define PRBS_CHK_BITCNT_EN to add the bit_count output (compared-bit counter).
module prbs_checker #(
  parameter int unsigned WIDTH       = 32,
  parameter logic [31:0] TAPS        = 32'h8020_0003,
  parameter int unsigned LOCK_CNT    = 64,
  parameter int unsigned WIN_LEN     = 256,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  input  logic        din,
  input  logic        clear,
  output logic        locked,
  output logic        err_pulse,
  output logic [31:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [31:0] bit_count
`endif
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FILL_END = FW'(WIDTH);
  localparam logic [15:0]   LOCK_C   = 16'(LOCK_CNT);
  localparam logic [15:0]   WIN_C    = 16'(WIN_LEN);
  localparam logic [15:0]   LOSS_C   = 16'(LOSS_THRESH);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_s;
  logic [FW-1:0]    r_fill;
  logic [15:0]      r_match;
  logic [15:0]      r_wbits;
  logic [15:0]      r_werr;
  logic             r_locked;
  logic             r_err_pulse;
  logic [31:0]      r_err_count;

  logic        w_pred;
  logic        w_err;
  logic [15:0] w_match_nx;
  logic [15:0] w_wbits_nx;
  logic [15:0] w_werr_nx;

  assign w_pred     = ^(r_s & TAPS[WIDTH-1:0]);
  assign w_err      = din != w_pred;
  assign w_match_nx = r_match + 16'd1;
  assign w_wbits_nx = r_wbits + 16'd1;
  assign w_werr_nx  = r_werr + {15'd0, w_err};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_s         <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_wbits     <= '0;
      r_werr      <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (din_valid) begin
        unique case (r_state)
          SEARCH: begin
            r_s <= {r_s[WIDTH-2:0], din};
            if (r_fill != FILL_END) begin
              r_fill <= r_fill + 1'b1;
            end else if (!w_err && r_s != '0) begin
              if (w_match_nx == LOCK_C) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
                r_match  <= '0;
                r_wbits  <= '0;
                r_werr   <= '0;
              end else begin
                r_match <= w_match_nx;
              end
            end else begin
              r_match <= '0;
            end
          end
          LOCKED: begin
            // Free-running prediction keeps one bad bit from propagating.
            r_s         <= {r_s[WIDTH-2:0], w_pred};
            r_err_pulse <= w_err;
            if (w_werr_nx == LOSS_C) begin
              r_state  <= SEARCH;
              r_locked <= 1'b0;
              r_fill   <= '0;
              r_match  <= '0;
            end
            if (w_wbits_nx == WIN_C) begin
              r_wbits <= '0;
              r_werr  <= '0;
            end else begin
              r_wbits <= w_wbits_nx;
              r_werr  <= w_werr_nx;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (clear) begin
      r_err_count <= '0;
    end else if (din_valid && r_state == LOCKED && w_err
                 && r_err_count != '1) begin
      r_err_count <= r_err_count + 32'd1;
    end
  end

`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] r_bit_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_count <= '0;
    end else if (clear) begin
      r_bit_count <= '0;
    end else if (din_valid && r_locked && r_bit_count != '1) begin
      r_bit_count <= r_bit_count + 32'd1;
    end
  end

  assign bit_count = r_bit_count;
`endif

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock timing, error counting, loss and clear.
// A local Fibonacci LFSR generator supplies the reference stream.
module tb_prbs_checker;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic        din = 1'b0;
  logic        clear = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [31:0] err_count;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_count;
`endif

  int          nchk = 0;
  int          nerr = 0;
  int          pulses = 0;
  int          p0;
  bit          saw_lock = 1'b0;
  logic [31:0] g = 32'd1;

  typedef struct {
    int          n;
    int          nflip;
    logic        exp_lock;
    logic [31:0] exp_cnt;
  } seg_t;

  seg_t tbl[13];

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
`ifdef PRBS_CHK_BITCNT_EN
    .bit_count (bit_count),
`endif
    .err_count (err_count)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic d, input logic clr);
    @(negedge clk);
    din_valid = vld;
    din       = d;
    clear     = clr;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clear     = 1'b0;
    if (err_pulse === 1'b1) pulses++;
    if (locked === 1'b1) saw_lock = 1'b1;
  endtask

  task automatic step(input logic vld, input logic flip, input logic clr);
    logic b;
    b = ^(g & TAPS);
    if (vld) begin
      g = {g[30:0], b};
      drive(1'b1, b ^ flip, clr);
    end else begin
      drive(1'b0, 1'($urandom_range(0, 1)), clr);
    end
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      din       = 1'($urandom_range(0, 1));
      din_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_count", err_count, 32'd0);
    rst       = 1'b0;
    din_valid = 1'b0;
    pulses    = 0;
    saw_lock  = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 10; k++)
      tbl[k] = '{256, 7, 1'b1, 32'(7 * (k + 1))};
    tbl[10] = '{15, 8, 1'b0, 32'd78};
    tbl[11] = '{95, 0, 1'b0, 32'd78};
    tbl[12] = '{1, 0, 1'b1, 32'd78};

    // Reset and idle
    do_reset();
    repeat (20) step(1'b0, 1'b0, 1'b0);
    chk("idle_locked", {31'd0, saw_lock}, 32'd0);
    chk("idle_count", err_count, 32'd0);
    chk("idle_pulses", 32'(pulses), 32'd0);

    // Clean lock from seed 1
    g = 32'd1;
    clean(95);
    chk("lock_at_95", {31'd0, locked}, 32'd0);
    clean(1);
    chk("lock_at_96", {31'd0, locked}, 32'd1);
    pulses = 0;
    clean(10000);
    chk("clean_count", err_count, 32'd0);
    chk("clean_pulses", 32'(pulses), 32'd0);
    chk("clean_locked", {31'd0, locked}, 32'd1);
`ifdef PRBS_CHK_BITCNT_EN
    chk("clean_bitcnt", bit_count, 32'd10000);
`endif

    // Single inverted bit
    clean(499);
    step(1'b1, 1'b1, 1'b0);
    chk("single_pulse", {31'd0, err_pulse}, 32'd1);
    chk("single_count", err_count, 32'd1);
    chk("single_locked", {31'd0, locked}, 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("single_pulse_off", {31'd0, err_pulse}, 32'd0);
    pulses = 0;
    clean(1000);
    chk("after_pulses", 32'(pulses), 32'd0);
    chk("after_count", err_count, 32'd1);
    chk("after_locked", {31'd0, locked}, 32'd1);

    // Asynchronous reset mid-operation
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_locked", {31'd0, locked}, 32'd0);
    chk("async_count", err_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All-zero stream must never lock
    do_reset();
    repeat (1000) drive(1'b1, 1'b0, 1'b0);
    chk("zero_locked", {31'd0, saw_lock}, 32'd0);
    chk("zero_count", err_count, 32'd0);

    // Window table: 7 errors/window retained, 8 lose, re-lock after 96
    do_reset();
    g = 32'h1234_5678;
    clean(96);
    chk("tbl_lock", {31'd0, locked}, 32'd1);
    for (int r = 0; r < 13; r++) begin
      p0 = pulses;
      for (int i = 0; i < tbl[r].n; i++)
        step(1'b1, (i < 2 * tbl[r].nflip) && (i % 2 == 0), 1'b0);
      chk($sformatf("row%0d_lock", r), {31'd0, locked},
          {31'd0, tbl[r].exp_lock});
      chk($sformatf("row%0d_count", r), err_count, tbl[r].exp_cnt);
      chk($sformatf("row%0d_pulses", r), 32'(pulses - p0),
          32'(tbl[r].nflip));
    end

    // Gapped valid, then clear colliding with an error
    do_reset();
    g = 32'd1;
    for (int k = 0; k < 95; k++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    chk("gap_lock_95", {31'd0, locked}, 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("gap_lock_96", {31'd0, locked}, 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("gap_lock_hold", {31'd0, locked}, 32'd1);
    step(1'b1, 1'b1, 1'b0);
    chk("gap_err_count", err_count, 32'd1);
    chk("gap_err_pulse", {31'd0, err_pulse}, 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("gap_idle_pulse", {31'd0, err_pulse}, 32'd0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_pulse", {31'd0, err_pulse}, 32'd1);
    chk("clr_count", err_count, 32'd0);
    chk("clr_locked", {31'd0, locked}, 32'd1);
`ifdef PRBS_CHK_BITCNT_EN
    chk("clr_bitcnt", bit_count, 32'd0);
`endif
    step(1'b1, 1'b0, 1'b0);
    chk("post_clr_count", err_count, 32'd0);
`ifdef PRBS_CHK_BITCNT_EN
    chk("bitcnt_1", bit_count, 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("bitcnt_hold", bit_count, 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("bitcnt_2", bit_count, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
